hlcp_bus_monitor: RTL

//  Consumes the two-flop-synchronised HLCP lines (scl_in_rs/sda_in_rs) and removes spikes with a per-line digital glitch filter.

---
 rtl/hlcp_pkg.sv | 13 +
 rtl/hlcp_glitch_filt.sv | 45 ++++
 rtl/hlcp_bus_monitor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hlcp_pkg.sv
// rtl/hlcp_pkg.sv - shared FSM encoding and filter constants for the HLCP bus monitor
package hlcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_FREE_WAIT = 2'd2
  } hlcp_state_e;

  localparam int unsigned HLCP_FILT_LEN   = 4;
  localparam int unsigned HLCP_FILT_CNT_W = 4;

endpackage

// File: rtl/hlcp_glitch_filt.sv
// rtl/hlcp_glitch_filt.sv - per-line digital glitch filter; output follows a level held FILT_LEN cycles
module hlcp_glitch_filt
  import hlcp_pkg::*;
#(
  parameter int unsigned FILT_LEN = HLCP_FILT_LEN
) (
  input  logic sys_clk,
  input  logic sys_resetb,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = HLCP_FILT_CNT_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;

  // The counter only advances while the raw level disagrees, so any agreement restarts the qualification.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      cnt_q  <= '0;
      dout_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/hlcp_bus_monitor.sv
// rtl/hlcp_bus_monitor.sv - HLCP bus monitor: filtered levels, edge/condition strobes, busy/free tracking
module hlcp_bus_monitor
  import hlcp_pkg::*;
#(
  parameter int unsigned FILT_LEN = HLCP_FILT_LEN,
  parameter int unsigned IDLE_W   = 10
) (
  input  logic              sys_clk,
  input  logic              sys_resetb,
  input  logic              mon_en,
  input  logic [IDLE_W-1:0] idle_limit,
  input  logic              scl_in_rs,
  input  logic              sda_in_rs,
  output logic              scl_f,
  output logic              sda_f,
  output logic              scl_rise,
  output logic              scl_fall,
  output logic              start_det,
  output logic              rstart_det,
  output logic              stop_det,
  output logic              bus_busy,
  output logic              bus_free
);

  localparam logic [IDLE_W-1:0] CNT_ONE = IDLE_W'(1);

  hlcp_state_e       state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              scl_dly_q, sda_dly_q;
  logic              start_cond, stop_cond;
  logic              idle_done;

  hlcp_glitch_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .sys_clk    (sys_clk),
    .sys_resetb (sys_resetb),
    .din        (scl_in_rs),
    .dout       (scl_f)
  );

  hlcp_glitch_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .sys_clk    (sys_clk),
    .sys_resetb (sys_resetb),
    .din        (sda_in_rs),
    .dout       (sda_f)
  );

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
    end else begin
      scl_dly_q <= scl_f;
      sda_dly_q <= sda_f;
    end
  end

  // Requiring scl_dly_q high rejects SDA edges that coincide with an SCL edge.
  assign scl_rise   =  scl_f & ~scl_dly_q;
  assign scl_fall   = ~scl_f &  scl_dly_q;
  assign start_cond =  scl_f & scl_dly_q & ~sda_f &  sda_dly_q;
  assign stop_cond  =  scl_f & scl_dly_q &  sda_f & ~sda_dly_q;
  assign idle_done  = (idle_limit == '0) || (idle_cnt_q == (idle_limit - CNT_ONE));

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    start_det  = 1'b0;
    rstart_det = 1'b0;
    stop_det   = 1'b0;
    bus_free   = 1'b0;
    if (!mon_en) begin
      state_d    = ST_IDLE;
      idle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_cond) begin
            state_d   = ST_BUSY;
            start_det = 1'b1;
          end else if (stop_cond) begin
            stop_det = 1'b1;
          end
        end
        ST_BUSY: begin
          if (stop_cond) begin
            state_d    = ST_FREE_WAIT;
            stop_det   = 1'b1;
            idle_cnt_d = '0;
          end else if (start_cond) begin
            rstart_det = 1'b1;
          end
        end
        ST_FREE_WAIT: begin
          if (start_cond) begin
            state_d   = ST_BUSY;
            start_det = 1'b1;
          end else if (scl_fall) begin
            // Someone is clocking without having issued a START; treat the bus as taken.
            state_d = ST_BUSY;
          end else if (stop_cond) begin
            stop_det = 1'b1;
          end else if (scl_f && sda_f) begin
            if (idle_done) begin
              state_d  = ST_IDLE;
              bus_free = 1'b1;
            end else if (idle_cnt_q != '1) begin
              idle_cnt_d = idle_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign bus_busy = (state_q != ST_IDLE);

endmodule
